// File: rtl/lif_step_sequencer_pkg.sv
// Shared types and defaults for the LIF neuron step sequencer.
package lif_seq_pkg;

    localparam int unsigned LIF_W            = 8;
    localparam int unsigned N_STEPS_DEF      = 64;
    localparam int unsigned DRAIN_CYCLES_DEF = 2;
    localparam int unsigned THRESH_DEF       = 50;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        GAP,
        DRAIN,
        OUT,
        CLEAR
    } seq_state_e;

endpackage

// File: rtl/lif_step_sequencer_if.sv
// Pixel/result/config handshakes plus neuron control bundle for lif_step_sequencer.
// Optional LIF_SEQ_EARLY_EXIT_EN adds cfg_max_count and res_early.
interface lif_step_sequencer_if;
    import lif_seq_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [LIF_W-1:0] pix_data;
    logic             cfg_we;
    logic [LIF_W-1:0] cfg_threshold;
    logic [LIF_W-1:0] cfg_steps;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [LIF_W-1:0] res_count;
    logic             n_data_en;
    logic             n_step_en;
    logic             n_clear_spike;
    logic             n_end_step;
    logic [LIF_W-1:0] n_input_current;
    logic [LIF_W-1:0] n_threshold;
    logic [LIF_W-1:0] n_sp_steps;
    logic             n_spike_out;
    logic [LIF_W-1:0] n_spike_count;
`ifdef LIF_SEQ_EARLY_EXIT_EN
    logic [LIF_W-1:0] cfg_max_count;
    logic             res_early;
`endif

    modport master (
        output pix_valid, pix_data, cfg_we, cfg_threshold, cfg_steps, res_ready,
               n_spike_out, n_spike_count,
`ifdef LIF_SEQ_EARLY_EXIT_EN
        output cfg_max_count,
        input  res_early,
`endif
        input  pix_ready, busy, res_valid, res_count, n_data_en, n_step_en,
               n_clear_spike, n_end_step, n_input_current, n_threshold, n_sp_steps
    );

    modport slave (
        input  pix_valid, pix_data, cfg_we, cfg_threshold, cfg_steps, res_ready,
               n_spike_out, n_spike_count,
`ifdef LIF_SEQ_EARLY_EXIT_EN
        input  cfg_max_count,
        output res_early,
`endif
        output pix_ready, busy, res_valid, res_count, n_data_en, n_step_en,
               n_clear_spike, n_end_step, n_input_current, n_threshold, n_sp_steps
    );

endinterface

// File: rtl/lif_step_sequencer_spike_clear.sv
// clear_spike generator: one pulse per latched spike, with a one-cycle hold-off
// covering the neuron's two-register spike_out path.
module lif_spike_clear (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic spike_i,
    output logic clear_o
);
    logic clear_q;

    assign clear_o = enable_i && spike_i && !clear_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clear_q <= 1'b0;
        else        clear_q <= clear_o;
    end

endmodule

// File: rtl/lif_step_sequencer.sv
// Sequences one LIF neuron over a pixel stream: load, S steps, drain, result, end_step.
// Optional LIF_SEQ_EARLY_EXIT_EN stops issuing steps once spike_count reaches cfg_max_count.
module lif_step_sequencer
    import lif_seq_pkg::*;
#(
    parameter int unsigned N_STEPS        = N_STEPS_DEF,
    parameter int unsigned STEP_GAP       = 0,
    parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
    parameter int unsigned THRESH_DEFAULT = THRESH_DEF
) (
    input logic                 clk,
    input logic                 reset_n,
    lif_step_sequencer_if.slave bus
);
    localparam logic [15:0]      GAP_LAST   = 16'(STEP_GAP - 1);
    localparam logic [15:0]      DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
    localparam logic [LIF_W-1:0] STEPS_RST  = LIF_W'(N_STEPS);
    localparam logic [LIF_W-1:0] THR_RST    = LIF_W'(THRESH_DEFAULT);

    seq_state_e       state_q, state_d;
    logic [LIF_W-1:0] step_cnt_q, step_cnt_d;
    logic [LIF_W-1:0] pix_q, pix_d;
    logic [LIF_W-1:0] thr_q, thr_d;
    logic [LIF_W-1:0] steps_q, steps_d;
    logic [LIF_W-1:0] res_q, res_d;
    logic [15:0]      wait_q, wait_d;
    logic [LIF_W:0]   step_nxt;
    logic             last_step, early_hit;
    logic             pix_ready, data_en, step_en, end_step, res_valid;

    // Terminal compare is one bit wider so S=255 never wraps.
    assign step_nxt  = {1'b0, step_cnt_q} + {{LIF_W{1'b0}}, 1'b1};
    assign last_step = (step_nxt == {1'b0, steps_q});

`ifdef LIF_SEQ_EARLY_EXIT_EN
    logic [LIF_W-1:0] max_q;
    logic             early_q;

    assign early_hit     = (max_q != '0) && (bus.n_spike_count >= max_q);
    assign bus.res_early = early_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q   <= '0;
            early_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.cfg_we) max_q <= bus.cfg_max_count;
            if (state_q == LOAD)
                early_q <= 1'b0;
            else if ((state_q == STEP || state_q == GAP) && early_hit)
                early_q <= 1'b1;
        end
    end
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            pix_q      <= '0;
            thr_q      <= THR_RST;
            steps_q    <= STEPS_RST;
            res_q      <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            pix_q      <= pix_d;
            thr_q      <= thr_d;
            steps_q    <= steps_d;
            res_q      <= res_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        pix_d      = pix_q;
        thr_d      = thr_q;
        steps_d    = steps_q;
        res_d      = res_q;
        wait_d     = '0;
        pix_ready  = 1'b0;
        data_en    = 1'b0;
        step_en    = 1'b0;
        end_step   = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                pix_ready = 1'b1;
                if (bus.cfg_we) begin
                    thr_d   = bus.cfg_threshold;
                    steps_d = (bus.cfg_steps == '0) ? STEPS_RST : bus.cfg_steps;
                end
                if (bus.pix_valid) begin
                    pix_d   = bus.pix_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_en    = 1'b1;
                step_cnt_d = '0;
                state_d    = STEP;
            end
            STEP: begin
                data_en = 1'b1;
                if (early_hit) begin
                    state_d = DRAIN;
                end else begin
                    step_en    = 1'b1;
                    step_cnt_d = step_nxt[LIF_W-1:0];
                    if (last_step)          state_d = DRAIN;
                    else if (STEP_GAP != 0) state_d = GAP;
                end
            end
            GAP: begin
                data_en = 1'b1;
                if (early_hit)              state_d = DRAIN;
                else if (wait_q == GAP_LAST) state_d = STEP;
                else                        wait_d  = wait_q + 16'd1;
            end
            DRAIN: begin
                data_en = 1'b1;
                if (wait_q == DRAIN_LAST) begin
                    res_d   = bus.n_spike_count;
                    state_d = OUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            OUT: begin
                data_en   = 1'b1;
                res_valid = 1'b1;
                if (bus.res_ready) state_d = CLEAR;
            end
            CLEAR: begin
                end_step = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lif_spike_clear u_clear (
        .clk      (clk),
        .rst_n    (reset_n),
        .enable_i (state_q != IDLE),
        .spike_i  (bus.n_spike_out),
        .clear_o  (bus.n_clear_spike)
    );

    assign bus.pix_ready       = pix_ready;
    assign bus.busy            = (state_q != IDLE);
    assign bus.res_valid       = res_valid;
    assign bus.res_count       = res_q;
    assign bus.n_data_en       = data_en;
    assign bus.n_step_en       = step_en;
    assign bus.n_end_step      = end_step;
    assign bus.n_input_current = pix_q;
    assign bus.n_threshold     = thr_q;
    assign bus.n_sp_steps      = steps_q;

endmodule

// File: tb/tb_lif_step_sequencer.sv
// Self-checking bench for lif_step_sequencer: behavioural neuron plus result scoreboard.
module tb_lif_step_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lif_step_sequencer_if bus0 ();
    lif_step_sequencer_if bus1 ();

    lif_step_sequencer #(.N_STEPS(64), .STEP_GAP(0), .DRAIN_CYCLES(2), .THRESH_DEFAULT(50)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    lif_step_sequencer #(.N_STEPS(64), .STEP_GAP(2), .DRAIN_CYCLES(2), .THRESH_DEFAULT(50)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integrate-and-fire neuron: reset-to-zero on spike, count saturates at 255.
    logic [9:0] acc;
    logic [7:0] cnt;
    logic       lat, dprev;
    assign bus0.n_spike_count = cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0; cnt <= '0; lat <= 1'b0; dprev <= 1'b0;
            bus0.n_spike_out <= 1'b0;
        end else begin
            dprev            <= bus0.n_data_en;
            bus0.n_spike_out <= lat;
            if (bus0.n_data_en && !dprev) begin
                acc <= '0; cnt <= '0; lat <= 1'b0;
            end else if (bus0.n_data_en && bus0.n_step_en) begin
                if (acc + {2'b00, bus0.n_input_current} >= {2'b00, bus0.n_threshold}) begin
                    acc <= '0;
                    cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    lat <= 1'b1;
                end else begin
                    acc <= acc + {2'b00, bus0.n_input_current};
                    if (bus0.n_clear_spike) lat <= 1'b0;
                end
            end else if (bus0.n_clear_spike) begin
                lat <= 1'b0;
            end
        end
    end

    function automatic int exp_count(input int pix, input int thr, input int steps);
        int a = 0;
        int c = 0;
        for (int i = 0; i < steps; i++) begin
            a += pix;
            if (a >= thr) begin
                a = 0;
                if (c < 255) c++;
            end
        end
        return c;
    endfunction

    typedef struct {
        int count;
        int lat;
        int steps;
        bit chk_clr;
    } exp_t;

    exp_t sb[$];
    int   thr_m = 50;
    int   steps_m = 64;

    // Monitor: per-pixel timing bookkeeping and scoreboard compare on result.
    int hs = -1000, hs_prev = -1000, rel, nstep = 0, first = -1, last = -1;
    int nclr = 0, drain_cnt = -1, end_exp = -1;
    bit pv = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (bus0.pix_valid && bus0.pix_ready) begin
                hs_prev = hs; hs = cyc;
                nstep = 0; first = -1; last = -1; nclr = 0; drain_cnt = -1;
            end
            rel = cyc - hs;
            if (bus0.n_step_en) begin
                nstep++;
                if (first < 0) first = rel;
                last = rel;
            end
            if (bus0.n_clear_spike) nclr++;
            if (sb.size() > 0 && rel == sb[0].lat - 1) drain_cnt = bus0.n_spike_count;
            if (bus0.res_valid && !pv) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("latency", rel, sb[0].lat);
                    check("res_count", bus0.res_count, sb[0].count);
                    check("count_at_drain", bus0.res_count, drain_cnt);
                    check("step_pulses", nstep, sb[0].steps);
                    check("first_step", first, 2);
                    check("last_step", last, sb[0].steps + 1);
                end
            end
            if (bus0.res_valid && bus0.res_ready) begin
                end_exp = cyc + 1;
                if (sb.size() > 0) begin
                    if (sb[0].chk_clr) check("zero_pix_clears", nclr, 0);
                    void'(sb.pop_front());
                end
            end
            if (bus0.n_end_step) begin
                check("end_step_cycle", cyc, end_exp);
                check("end_step_data_en", bus0.n_data_en, 0);
            end
            pv = bus0.res_valid;
        end
    end

    task automatic send_pixel(input int pix, input bit chk_clr);
        int unsigned t = 0;
        exp_t e;
        bus0.pix_valid = 1'b1;
        bus0.pix_data  = 8'(pix);
        while (!bus0.pix_ready && t < 1000) begin
            tick();
            t++;
        end
        if (!bus0.pix_ready) begin
            check("pix_ready_timeout", 0, 1);
            bus0.pix_valid = 1'b0;
            return;
        end
        e.count   = exp_count(pix, thr_m, steps_m);
        e.lat     = 2 + steps_m + 2;
        e.steps   = steps_m;
        e.chk_clr = chk_clr;
        sb.push_back(e);
        tick();
        bus0.pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while ((sb.size() != 0 || bus0.busy) && t < 3000) begin
            tick();
            t++;
        end
        if (sb.size() != 0 || bus0.busy) begin
            check("idle_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic cfg_write(input int thr, input int steps);
        bus0.cfg_we        = 1'b1;
        bus0.cfg_threshold = 8'(thr);
        bus0.cfg_steps     = 8'(steps);
        tick();
        bus0.cfg_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int v0, fv, rc;
        int gsteps[$];

        bus0.pix_valid = 1'b0; bus0.pix_data = '0; bus0.cfg_we = 1'b0;
        bus0.cfg_threshold = '0; bus0.cfg_steps = '0; bus0.res_ready = 1'b1;
        bus1.pix_valid = 1'b0; bus1.pix_data = '0; bus1.cfg_we = 1'b0;
        bus1.cfg_threshold = '0; bus1.cfg_steps = '0; bus1.res_ready = 1'b1;
        bus1.n_spike_out = 1'b0; bus1.n_spike_count = 8'd7;
`ifdef LIF_SEQ_EARLY_EXIT_EN
        bus0.cfg_max_count = '0;
        bus1.cfg_max_count = '0;
`endif
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();

        check("rst_pix_ready", bus0.pix_ready, 1);
        check("rst_threshold", bus0.n_threshold, 50);
        check("rst_sp_steps", bus0.n_sp_steps, 64);
        check("rst_busy", bus0.busy, 0);
        check("rst_res_valid", bus0.res_valid, 0);
        check("rst_res_count", bus0.res_count, 0);
        check("rst_flags", {bus0.n_data_en, bus0.n_step_en, bus0.n_clear_spike, bus0.n_end_step}, 0);
        check("rst_input_current", bus0.n_input_current, 0);

        // Default run, then two back-to-back pixels for throughput.
        send_pixel(200, 1'b0);
        wait_idle();
        send_pixel(30, 1'b0);
        send_pixel(17, 1'b0);
        wait_idle();
        check("throughput", hs - hs_prev, 70);

        send_pixel(0, 1'b1);
        wait_idle();

        // Config written in the same cycle as the pixel handshake.
        bus0.cfg_we = 1'b1; bus0.cfg_threshold = 8'd100; bus0.cfg_steps = 8'd10;
        thr_m = 100; steps_m = 10;
        send_pixel(60, 1'b0);
        bus0.cfg_we = 1'b0;
        wait_idle();
        check("cfg_threshold", bus0.n_threshold, 100);
        check("cfg_steps", bus0.n_sp_steps, 10);

        cfg_write(50, 255);
        thr_m = 50; steps_m = 255;
        check("cfg_steps_255", bus0.n_sp_steps, 255);
        send_pixel(200, 1'b0);
        wait_idle();

        cfg_write(50, 0);
        steps_m = 64;
        check("cfg_steps_zero", bus0.n_sp_steps, 64);

        // Result backpressure; cfg_we while busy must be ignored.
        bus0.res_ready = 1'b0;
        send_pixel(30, 1'b0);
        t = 0;
        while (!bus0.res_valid && t < 200) begin
            tick();
            t++;
        end
        check("bp_res_valid_seen", bus0.res_valid, 1);
        v0 = bus0.res_count;
        for (int i = 0; i < 10; i++) begin
            check("bp_res_valid", bus0.res_valid, 1);
            check("bp_res_count", bus0.res_count, v0);
            check("bp_pix_ready", bus0.pix_ready, 0);
            if (i == 3) begin
                bus0.cfg_we = 1'b1; bus0.cfg_threshold = 8'd9; bus0.cfg_steps = 8'd5;
            end
            if (i == 4) bus0.cfg_we = 1'b0;
            tick();
        end
        check("bp_threshold_kept", bus0.n_threshold, 50);
        check("bp_steps_kept", bus0.n_sp_steps, 64);
        bus0.res_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a run abandons the pixel.
        send_pixel(200, 1'b0);
        t = 0;
        while (nstep < 30 && t < 200) begin
            tick();
            t++;
        end
        check("mid_steps_reached", nstep >= 30, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", bus0.busy, 0);
        check("mid_rst_res_valid", bus0.res_valid, 0);
        check("mid_rst_step_en", bus0.n_step_en, 0);
        check("mid_rst_data_en", bus0.n_data_en, 0);
        check("mid_rst_pix_ready", bus0.pix_ready, 1);
        sb.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (80) tick();
        send_pixel(200, 1'b0);
        wait_idle();

        // Stepping with STEP_GAP=2 and 4 steps on the second instance.
        bus1.cfg_we = 1'b1; bus1.cfg_steps = 8'd4; bus1.cfg_threshold = 8'd50;
        bus1.pix_valid = 1'b1; bus1.pix_data = 8'd200;
        @(negedge clk);
        check("gap_pix_ready", bus1.pix_ready, 1);
        tick();
        bus1.cfg_we = 1'b0; bus1.pix_valid = 1'b0;
        fv = -1; rc = -1;
        for (int r = 1; r <= 20; r++) begin
            @(negedge clk);
            if (bus1.n_step_en) gsteps.push_back(r);
            if (bus1.res_valid && fv < 0) begin
                fv = r;
                rc = bus1.res_count;
            end
        end
        check("gap_step_pulses", gsteps.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gsteps.size()) check("gap_step_cycle", gsteps[i], 2 + 3 * i);
        check("gap_res_latency", fv, 14);
        check("gap_res_count", rc, 7);
        check("gap_idle", bus1.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
